// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, field/control decode, load-use hazard stall and ID/EX latch.
// Defining ID_STALL_CNT_EN adds a saturating stall-cycle counter on port stall_cnt.
module id_stage #(
   parameter int XLEN = 32
`ifdef ID_STALL_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   input  logic            ex_flush,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] rf_a,
   input  logic [XLEN-1:0] rf_b,
   output logic [4:0]      rf_r1num,
   output logic [4:0]      rf_r2num,
   output logic            id_stall,
   output logic            idex_valid,
   output logic [XLEN-1:0] idex_pc,
   output logic [XLEN-1:0] idex_a,
   output logic [XLEN-1:0] idex_b,
   output logic [XLEN-1:0] idex_imm,
   output logic [4:0]      idex_rs,
   output logic [4:0]      idex_rt,
   output logic [4:0]      idex_rd,
   output logic [5:0]      idex_op,
   output logic [5:0]      idex_funct,
   output logic            idex_reg_write,
   output logic            idex_mem_read,
   output logic            idex_mem_write
`ifdef ID_STALL_CNT_EN
   , output logic [CNT_W-1:0] stall_cnt
`endif
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [5:0]      op;
      logic [5:0]      funct;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } idex_t;

   logic            ifid_valid;
   logic [XLEN-1:0] ifid_pc;
   logic [31:0]     ifid_instr;
   logic [5:0]      op;
   logic [4:0]      rs, rt, dest;
   logic            wr_op, uses_rt;
   idex_t           dec, idex_q;

   assign op       = ifid_instr[31:26];
   assign rs       = ifid_instr[25:21];
   assign rt       = ifid_instr[20:16];
   assign dest     = (op == 6'h00) ? ifid_instr[15:11] : rt;
   assign rf_r1num = rs;
   assign rf_r2num = rt;

   always_comb begin
      wr_op   = 1'b0;
      uses_rt = 1'b0;
      case (op)
         6'h00: begin
            wr_op   = |ifid_instr;
            uses_rt = 1'b1;
         end
         6'h04, 6'h05, 6'h2B:                uses_rt = 1'b1;
         6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23: wr_op   = 1'b1;
         default: ;
      endcase
   end

   // An empty slot decodes to a bubble: every control forced low.
   always_comb begin
      dec           = '0;
      dec.valid     = ifid_valid;
      dec.pc        = ifid_pc;
      dec.a         = rf_a;
      dec.b         = rf_b;
      dec.imm       = {{(XLEN-16){ifid_instr[15]}}, ifid_instr[15:0]};
      dec.rs        = rs;
      dec.rt        = rt;
      dec.rd        = dest;
      dec.op        = op;
      dec.funct     = ifid_instr[5:0];
      dec.reg_write = ifid_valid & wr_op & (dest != 5'd0);
      dec.mem_read  = ifid_valid & (op == 6'h23);
      dec.mem_write = ifid_valid & (op == 6'h2B);
   end

   // Gated by rst_n so the stall is never seen while the pipe is held in reset.
   assign id_stall = rst_n & ifid_valid & ex_mem_read & idex_q.valid & (ex_rd != 5'd0) &
                     ((ex_rd == rs) | (uses_rt & (ex_rd == rt))) & ~ex_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ifid_valid <= 1'b0;
         ifid_pc    <= '0;
         ifid_instr <= '0;
         idex_q     <= '0;
      end else if (ex_flush) begin
         ifid_valid       <= 1'b0;
         idex_q.valid     <= 1'b0;
         idex_q.reg_write <= 1'b0;
         idex_q.mem_read  <= 1'b0;
         idex_q.mem_write <= 1'b0;
      end else if (id_stall) begin
         idex_q <= '0;
      end else begin
         ifid_valid <= if_valid;
         ifid_pc    <= if_pc;
         ifid_instr <= if_instr;
         idex_q     <= dec;
      end
   end

`ifdef ID_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (id_stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end
`endif

   assign idex_valid     = idex_q.valid;
   assign idex_pc        = idex_q.pc;
   assign idex_a         = idex_q.a;
   assign idex_b         = idex_q.b;
   assign idex_imm       = idex_q.imm;
   assign idex_rs        = idex_q.rs;
   assign idex_rt        = idex_q.rt;
   assign idex_rd        = idex_q.rd;
   assign idex_op        = idex_q.op;
   assign idex_funct     = idex_q.funct;
   assign idex_reg_write = idex_q.reg_write;
   assign idex_mem_read  = idex_q.mem_read;
   assign idex_mem_write = idex_q.mem_write;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios then randomized traffic vs a decode model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n, if_valid, ex_flush, ex_mem_read;
   logic [31:0] if_pc, if_instr, rf_a, rf_b;
   logic [4:0]  ex_rd;
   logic [4:0]  rf_r1num, rf_r2num;
   logic        id_stall, idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
   logic [31:0] idex_pc, idex_a, idex_b, idex_imm;
   logic [4:0]  idex_rs, idex_rt, idex_rd;
   logic [5:0]  idex_op, idex_funct;
`ifdef ID_STALL_CNT_EN
   localparam int CW = 2;
   logic [CW-1:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   id_stage #(.XLEN(32)
`ifdef ID_STALL_CNT_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .ex_flush(ex_flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .rf_a(rf_a), .rf_b(rf_b),
      .rf_r1num(rf_r1num), .rf_r2num(rf_r2num), .id_stall(id_stall), .idex_valid(idex_valid),
      .idex_pc(idex_pc), .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_op(idex_op),
      .idex_funct(idex_funct), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
      .idex_mem_write(idex_mem_write)
`ifdef ID_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   typedef struct packed {
      logic v; logic [31:0] pc, a, b, imm; logic [4:0] rs, rt, rd;
      logic [5:0] op, funct; logic rw, mr, mw;
   } exp_t;

   int          checks = 0, errors = 0, m_cnt = 0;
   bit          armed = 1'b0;
   logic        last_stall;
   logic        m_v;
   logic [31:0] m_pc, m_ins;
   exp_t        m_ex;

   // Expected ID/EX contents for one instruction, straight from the opcode tables.
   function automatic exp_t decode(input logic v, input logic [31:0] pc, ins, a, b);
      exp_t d;
      logic [5:0] o;
      o       = ins[31:26];
      d       = '0;
      d.v     = v;
      d.pc    = pc;
      d.a     = a;
      d.b     = b;
      d.imm   = 32'($signed(ins[15:0]));
      d.rs    = ins[25:21];
      d.rt    = ins[20:16];
      d.rd    = (o == 6'd0) ? ins[15:11] : ins[20:16];
      d.op    = o;
      d.funct = ins[5:0];
      d.rw    = v && (d.rd != 5'd0) && ((o inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23}) ||
                                        (o == 6'd0 && ins != 32'd0));
      d.mr    = v && (o == 6'h23);
      d.mw    = v && (o == 6'h2B);
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic emr, input logic [4:0] erd);
      logic hz;
      @(negedge clk);
      rst_n = rst; if_valid = v; if_pc = pc; if_instr = ins;
      ex_flush = fl; ex_mem_read = emr; ex_rd = erd;
      rf_a = $urandom; rf_b = $urandom;
      #1;
      hz = rst && m_v && emr && m_ex.v && (erd != 5'd0) && !fl &&
           ((erd == m_ins[25:21]) ||
            ((m_ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B}) && (erd == m_ins[20:16])));
      last_stall = id_stall;
      if (armed) begin
         chk("id_stall", 32'(id_stall), 32'(hz));
         chk("rf_r1num", 32'(rf_r1num), 32'(m_ins[25:21]));
         chk("rf_r2num", 32'(rf_r2num), 32'(m_ins[20:16]));
      end
      @(posedge clk);
      if (!rst) begin
         m_v = 1'b0; m_pc = '0; m_ins = '0; m_ex = '0; m_cnt = 0; armed = 1'b1;
      end else if (fl) begin
         m_v = 1'b0; m_ex.v = 1'b0; m_ex.rw = 1'b0; m_ex.mr = 1'b0; m_ex.mw = 1'b0;
      end else if (hz) begin
         m_ex = '0;
`ifdef ID_STALL_CNT_EN
         if (m_cnt < (1 << CW) - 1) m_cnt++;
`endif
      end else begin
         m_ex = decode(m_v, m_pc, m_ins, rf_a, rf_b);
         m_v = v; m_pc = pc; m_ins = ins;
      end
      #1;
      chk("idex_valid", 32'(idex_valid), 32'(m_ex.v));
      chk("idex_reg_write", 32'(idex_reg_write), 32'(m_ex.rw));
      chk("idex_mem_read", 32'(idex_mem_read), 32'(m_ex.mr));
      chk("idex_mem_write", 32'(idex_mem_write), 32'(m_ex.mw));
      if (m_ex.v) begin
         chk("idex_pc", idex_pc, m_ex.pc);
         chk("idex_a", idex_a, m_ex.a);
         chk("idex_b", idex_b, m_ex.b);
         chk("idex_imm", idex_imm, m_ex.imm);
         chk("idex_rs", 32'(idex_rs), 32'(m_ex.rs));
         chk("idex_rt", 32'(idex_rt), 32'(m_ex.rt));
         chk("idex_rd", 32'(idex_rd), 32'(m_ex.rd));
         chk("idex_op", 32'(idex_op), 32'(m_ex.op));
         chk("idex_funct", 32'(idex_funct), 32'(m_ex.funct));
      end
`ifdef ID_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
   endtask

   // Next fetch with EX inputs reflecting what the model says is now in EX.
   task automatic nxt(input logic v, input logic [31:0] pc, input logic [31:0] ins);
      step(1'b1, v, pc, ins, 1'b0, m_ex.v & m_ex.mr, m_ex.rd);
   endtask

   initial begin
      logic [5:0]  ops [9];
      logic [31:0] ins;
      logic        follow;
      ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};
      m_v = 1'b0; m_pc = '0; m_ins = '0; m_ex = '0;

      // reset with fetch active
      step(1'b0, 1'b1, 32'h40, 32'h20010005, 1'b0, 1'b0, 5'd0);
      step(1'b0, 1'b1, 32'h44, 32'h20010005, 1'b0, 1'b0, 5'd0);
      chk("rst_valid", 32'(idex_valid), 32'd0);
      chk("rst_pc", idex_pc, 32'd0);
      chk("rst_imm", idex_imm, 32'd0);
      chk("rst_stall", 32'(last_stall), 32'd0);

      // addi $1,$0,5 reaches ID/EX two cycles after being presented
      nxt(1'b1, 32'h100, 32'h20010005);
      nxt(1'b0, 32'h104, 32'h0);
      chk("addi_valid", 32'(idex_valid), 32'd1);
      chk("addi_imm", idex_imm, 32'd5);
      chk("addi_rd", 32'(idex_rd), 32'd1);
      chk("addi_rw", 32'(idex_reg_write), 32'd1);
      chk("addi_pc", idex_pc, 32'h100);

      // lw $2,0($1) ; add $3,$2,$1 -> one stall, one bubble
      nxt(1'b1, 32'h200, 32'h8C220000);
      nxt(1'b1, 32'h204, 32'h00411820);
      nxt(1'b0, 32'h208, 32'h0);
      chk("lu_stall", 32'(last_stall), 32'd1);
      chk("lu_bubble", 32'(idex_valid), 32'd0);
      nxt(1'b0, 32'h208, 32'h0);
      chk("lu_nostall", 32'(last_stall), 32'd0);
      chk("lu_add_valid", 32'(idex_valid), 32'd1);
      chk("lu_add_rs", 32'(idex_rs), 32'd2);
      chk("lu_add_rd", 32'(idex_rd), 32'd3);

      // lw $0 never stalls; sw $5 after lw $5 stalls through rt
      nxt(1'b1, 32'h300, 32'h8C200000);
      nxt(1'b1, 32'h304, 32'h00011820);
      nxt(1'b0, 32'h308, 32'h0);
      chk("r0_nostall", 32'(last_stall), 32'd0);
      nxt(1'b1, 32'h310, 32'h8C250000);
      nxt(1'b1, 32'h314, 32'hAC250004);
      nxt(1'b0, 32'h318, 32'h0);
      chk("sw_rt_stall", 32'(last_stall), 32'd1);
      nxt(1'b0, 32'h318, 32'h0);
      chk("sw_mw", 32'(idex_mem_write), 32'd1);

      // flush coincident with a load-use stall
      nxt(1'b1, 32'h400, 32'h8C250000);
      nxt(1'b1, 32'h404, 32'hAC250004);
      step(1'b1, 1'b1, 32'h408, 32'h20010005, 1'b1, m_ex.v & m_ex.mr, m_ex.rd);
      chk("fl_nostall", 32'(last_stall), 32'd0);
      chk("fl_idex_valid", 32'(idex_valid), 32'd0);
      nxt(1'b1, 32'h40C, 32'h20010005);
      chk("fl_ifid_empty", 32'(idex_valid), 32'd0);

`ifdef ID_STALL_CNT_EN
      for (int k = 0; k < 5; k++) begin
         nxt(1'b1, 32'h500, 32'h8C220000);
         nxt(1'b1, 32'h504, 32'h00411820);
         nxt(1'b0, 32'h508, 32'h0);
         nxt(1'b0, 32'h508, 32'h0);
      end
      chk("cnt_sat", 32'(stall_cnt), 32'd3);
`endif

      // randomized traffic on a small register set to provoke hazards
      for (int i = 0; i < 500; i++) begin
         ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
         if ($urandom_range(0, 15) == 0) ins = 32'd0;
         follow = $urandom_range(0, 1) == 1;
         step($urandom_range(0, 39) != 0, $urandom_range(0, 4) != 0, $urandom, ins,
              $urandom_range(0, 7) == 0,
              follow ? (m_ex.v & m_ex.mr) : 1'($urandom),
              follow ? m_ex.rd : 5'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
